ahb_lite_simple_master: RTL
===========================

Name: ahb_lite_simple_master

Overview:
- AHB-lite initiator. Turns a simple valid/ready command port into single NONSEQ AHB-lite transfers.
- Drives the `ahb_sync_sram` slave port, and any other AHB-lite slave in the SoC, from non-CPU agents such as the boot loader and a future DMA engine.
- Overlaps address and data phases, so back-to-back commands run at one transfer per cycle when the slave has no wait states.
- Handles exclusive-access signalling and the two-cycle AHB ERROR response, including replay of a command cancelled by an error.

Parameters:
- W_ADDR, 32, address width.
- W_DATA, 32, data width (fixed at 32 for this SoC).
- HMASTER_ID, 8'h02, value driven on ahbm_hmaster.

Ports:
- clk  in  1  system clock; the only clock.
- rst_n  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at posedge clk.
- cmd_addr  in  W_ADDR  byte address.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_size  in  3  HSIZE encoding, 0..2 only.
- cmd_wdata  in  W_DATA  write data, already lane-positioned by the caller.
- cmd_excl  in  1  exclusive access (LR/SC style).
- rsp_valid  out  1  one-cycle completion pulse; no backpressure.
- rsp_rdata  out  W_DATA  read data, valid with rsp_valid.
- rsp_err  out  1  slave returned ERROR.
- rsp_exokay  out  1  hexokay sampled at completion.
- ahbm_haddr  out  W_ADDR
- ahbm_hwrite  out  1
- ahbm_htrans  out  2  IDLE (00) or NONSEQ (10) only.
- ahbm_hsize  out  3
- ahbm_hburst  out  3  constant 3'b000 (SINGLE).
- ahbm_hprot  out  4  constant 4'b0011.
- ahbm_hmastlock  out  1  constant 0.
- ahbm_hexcl  out  1
- ahbm_hmaster  out  8  constant HMASTER_ID.
- ahbm_hwdata  out  W_DATA
- ahbm_hready  in  1
- ahbm_hresp  in  1
- ahbm_hrdata  in  W_DATA
- ahbm_hexokay  in  1

Behaviour:
- Reset (asynchronous, active-low, takes effect immediately):
  - htrans = IDLE; haddr, hwrite, hsize, hexcl, hwdata = 0.
  - rsp_valid, rsp_err, rsp_exokay = 0; rsp_rdata = 0.
  - Data-phase and replay flags cleared.
  - A reset in the middle of a transfer abandons it; no response is generated.
- All AHB outputs are registered. cmd_ready = ahbm_hready && !replay_valid && !err_first (combinational).
- Address phase:
  - On a posedge with ahbm_hready=1: if replay_valid, load the replay command as NONSEQ; else if cmd_valid && cmd_ready, load the cmd_* fields as NONSEQ; else drive IDLE.
  - With ahbm_hready=0 the address-phase registers hold, except in the error case below.
- Data phase:
  - A NONSEQ sampled with hready=1 sets dph_valid and moves hwdata and the write/excl attributes into the data-phase registers. hwdata stays stable until the data phase completes.
- Completion:
  - When dph_valid && ahbm_hready, the next cycle pulses rsp_valid with rsp_rdata = hrdata (reads; 0 for writes), rsp_err = hresp, rsp_exokay = hexokay (only for excl accesses, else 0).
  - Latency with zero wait states: command accepted at edge N, address phase in cycle N+1, rsp_valid in cycle N+3.
  - Each wait state adds one cycle.
- Error, first cycle (dph_valid && hresp && !hready):
  - err_first is set.
  - If the address-phase register holds a NONSEQ, copy it into the replay register, set replay_valid, and force htrans = IDLE at that edge.
- Error, second cycle (hready && hresp): completes with rsp_err=1. The replay is issued at the same edge when replay_valid is set.
- Commands are never lost or duplicated. Responses come back in command order.
- Exclusive write with hexokay=0: rsp_err=0, rsp_exokay=0, and the caller treats the SC as failed. The master never retries it.
- hsize > 2 is illegal. The SIM_MODE assertion $display + $finish fires on it.
- Simultaneous completion and new acceptance in the same cycle is the normal pipelined case and must not stall.

Decomposition:
- Shared package / `define.vh` constants: HTRANS_IDLE, HTRANS_NONSEQ, HSIZE_B/H/W, HBURST_SINGLE, HPROT_DATA_PRIV.
- No sub-module; one flat module of about 200 RTL lines.

Test Plan:
- Single read, addr 0x0000_0100, zero wait states -> htrans NONSEQ in cycle 1, rsp_valid in cycle 3 with rsp_rdata = slave data 0xDEADBEEF, rsp_err=0.
- Four back-to-back word writes 0x10..0x1C, cmd_valid held high -> four consecutive NONSEQ cycles, hwdata one cycle behind each address, four rsp_valid pulses on consecutive cycles.
- Byte write at 0x103, slave inserts 3 wait states -> haddr, hsize=0 and hwdata held for 3 cycles, cmd_ready=0 for 3 cycles, one rsp_valid afterwards.
- Read to 0x200 gets ERROR while a pipelined write to 0x204 is in its address phase -> htrans forced IDLE in the second error cycle, rsp_err=1 for 0x200, the write to 0x204 re-issued, then completes with rsp_err=0.
- Exclusive read 0x300, exclusive write 0x300 with slave hexokay=1 -> rsp_exokay=1. Repeat with hexokay=0 -> rsp_exokay=0, rsp_err=0.
- Assert rst_n low during a data phase with hready=0 -> htrans IDLE and rsp_valid 0 immediately. After release, a new read completes normally.

Source files
------------

// File: rtl/ahb_lite_simple_master_pkg.sv
// Shared AHB-lite encodings and the transfer-attribute record used by the simple master.
package ahb_lite_simple_master_pkg;

  localparam logic [1:0] HTRANS_IDLE     = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ   = 2'b10;

  localparam logic [2:0] HSIZE_B         = 3'd0;
  localparam logic [2:0] HSIZE_H         = 3'd1;
  localparam logic [2:0] HSIZE_W         = 3'd2;

  localparam logic [2:0] HBURST_SINGLE   = 3'b000;
  localparam logic [3:0] HPROT_DATA_PRIV = 4'b0011;

  typedef struct packed {
    logic       write;
    logic [2:0] size;
    logic       excl;
  } xfer_attr_t;

  function automatic logic size_legal(input logic [2:0] size);
    return (size == HSIZE_B) || (size == HSIZE_H) || (size == HSIZE_W);
  endfunction

endpackage

// File: rtl/ahb_lite_simple_master.sv
// AHB-lite initiator: valid/ready commands become pipelined single NONSEQ transfers,
// with ERROR handling that replays a transfer cancelled in its address phase.
module ahb_lite_simple_master
  import ahb_lite_simple_master_pkg::*;
#(
  parameter int unsigned W_ADDR     = 32,
  parameter int unsigned W_DATA     = 32,
  parameter logic [7:0]  HMASTER_ID = 8'h02
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [W_ADDR-1:0] cmd_addr,
  input  logic              cmd_write,
  input  logic [2:0]        cmd_size,
  input  logic [W_DATA-1:0] cmd_wdata,
  input  logic              cmd_excl,

  output logic              rsp_valid,
  output logic [W_DATA-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_exokay,

  output logic [W_ADDR-1:0] ahbm_haddr,
  output logic              ahbm_hwrite,
  output logic [1:0]        ahbm_htrans,
  output logic [2:0]        ahbm_hsize,
  output logic [2:0]        ahbm_hburst,
  output logic [3:0]        ahbm_hprot,
  output logic              ahbm_hmastlock,
  output logic              ahbm_hexcl,
  output logic [7:0]        ahbm_hmaster,
  output logic [W_DATA-1:0] ahbm_hwdata,
  input  logic              ahbm_hready,
  input  logic              ahbm_hresp,
  input  logic [W_DATA-1:0] ahbm_hrdata,
  input  logic              ahbm_hexokay
);

  // Address phase
  logic [W_ADDR-1:0] haddr_q;
  xfer_attr_t        aph_q;
  logic [1:0]        htrans_q;
  logic [W_DATA-1:0] aph_wdata_q;

  // Data phase
  logic              dph_valid_q;
  logic              dph_write_q;
  logic              dph_excl_q;
  logic [W_DATA-1:0] hwdata_q;

  // Replay of an address phase cancelled by an ERROR response
  logic              replay_valid_q;
  logic [W_ADDR-1:0] rp_addr_q;
  xfer_attr_t        rp_attr_q;
  logic [W_DATA-1:0] rp_wdata_q;
  logic              err_first_q;

  logic              rsp_valid_q, rsp_valid_d;
  logic [W_DATA-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_exokay_q, rsp_exokay_d;

  logic              aph_nonseq;
  logic              accept;
  logic              complete;
  logic              err_first_cyc;
  xfer_attr_t        cmd_attr;

  assign cmd_ready     = ahbm_hready && !replay_valid_q && !err_first_q;
  assign accept        = cmd_valid && cmd_ready;
  assign aph_nonseq    = (htrans_q == HTRANS_NONSEQ);
  assign complete      = dph_valid_q && ahbm_hready;
  assign err_first_cyc = dph_valid_q && ahbm_hresp && !ahbm_hready;
  assign cmd_attr      = '{write: cmd_write, size: cmd_size, excl: cmd_excl};

  always_comb begin
    rsp_valid_d  = complete;
    rsp_rdata_d  = '0;
    rsp_err_d    = 1'b0;
    rsp_exokay_d = 1'b0;
    if (complete) begin
      rsp_rdata_d  = dph_write_q ? '0 : ahbm_hrdata;
      rsp_err_d    = ahbm_hresp;
      rsp_exokay_d = dph_excl_q & ahbm_hexokay;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      haddr_q        <= '0;
      aph_q          <= '0;
      htrans_q       <= HTRANS_IDLE;
      aph_wdata_q    <= '0;
      dph_valid_q    <= 1'b0;
      dph_write_q    <= 1'b0;
      dph_excl_q     <= 1'b0;
      hwdata_q       <= '0;
      replay_valid_q <= 1'b0;
      rp_addr_q      <= '0;
      rp_attr_q      <= '0;
      rp_wdata_q     <= '0;
      err_first_q    <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_rdata_q    <= '0;
      rsp_err_q      <= 1'b0;
      rsp_exokay_q   <= 1'b0;
    end else begin
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
      rsp_exokay_q <= rsp_exokay_d;

      if (ahbm_hready) begin
        err_first_q <= 1'b0;
        dph_valid_q <= aph_nonseq;
        if (aph_nonseq) begin
          hwdata_q    <= aph_wdata_q;
          dph_write_q <= aph_q.write;
          dph_excl_q  <= aph_q.excl;
        end
        // A pending replay always wins over a new command to keep command order.
        if (replay_valid_q) begin
          htrans_q       <= HTRANS_NONSEQ;
          haddr_q        <= rp_addr_q;
          aph_q          <= rp_attr_q;
          aph_wdata_q    <= rp_wdata_q;
          replay_valid_q <= 1'b0;
        end else if (accept) begin
          htrans_q    <= HTRANS_NONSEQ;
          haddr_q     <= cmd_addr;
          aph_q       <= cmd_attr;
          aph_wdata_q <= cmd_wdata;
        end else begin
          htrans_q <= HTRANS_IDLE;
        end
      end else if (err_first_cyc) begin
        err_first_q <= 1'b1;
        if (aph_nonseq) begin
          rp_addr_q      <= haddr_q;
          rp_attr_q      <= aph_q;
          rp_wdata_q     <= aph_wdata_q;
          replay_valid_q <= 1'b1;
          htrans_q       <= HTRANS_IDLE;
        end
      end
    end
  end

  assign rsp_valid      = rsp_valid_q;
  assign rsp_rdata      = rsp_rdata_q;
  assign rsp_err        = rsp_err_q;
  assign rsp_exokay     = rsp_exokay_q;

  assign ahbm_haddr     = haddr_q;
  assign ahbm_hwrite    = aph_q.write;
  assign ahbm_htrans    = htrans_q;
  assign ahbm_hsize     = aph_q.size;
  assign ahbm_hburst    = HBURST_SINGLE;
  assign ahbm_hprot     = HPROT_DATA_PRIV;
  assign ahbm_hmastlock = 1'b0;
  assign ahbm_hexcl     = aph_q.excl;
  assign ahbm_hmaster   = HMASTER_ID;
  assign ahbm_hwdata    = hwdata_q;

`ifdef SIM_MODE
  always @(posedge clk) begin
    if (rst_n && accept) begin
      assert (size_legal(cmd_size))
        else $fatal(1, "ahb_lite_simple_master: illegal cmd_size %0d", cmd_size);
    end
  end
`endif

endmodule
